// File: rtl/car_pkg.sv
// Shared encodings for the car drive path: tracker modes, wheel commands,
// sequencer states and the H-bridge pin patterns of each wheel.
package car_pkg;

  typedef enum logic [1:0] {
    M_STRAIGHT = 2'b00,
    M_LEFT     = 2'b01,
    M_RIGHT    = 2'b10,
    M_BACK     = 2'b11
  } mode_e;

  typedef enum logic [1:0] {W_FWD, W_REV, W_COAST, W_BRAKE} wheel_e;

  localparam logic [2:0] PH_IDLE      = 3'd0;
  localparam logic [2:0] PH_DRIVE     = 3'd1;
  localparam logic [2:0] PH_DEADTIME  = 3'd2;
  localparam logic [2:0] PH_BLOCKED   = 3'd3;
  localparam logic [2:0] PH_LOST_HALT = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE      = PH_IDLE,
    S_DRIVE     = PH_DRIVE,
    S_DEADTIME  = PH_DEADTIME,
    S_BLOCKED   = PH_BLOCKED,
    S_LOST_HALT = PH_LOST_HALT
  } state_e;

  // Right motor is mounted mirrored, so its FWD/REV pin patterns are swapped.
  localparam logic [1:0] L_PINS_FWD = 2'b10;
  localparam logic [1:0] L_PINS_REV = 2'b01;
  localparam logic [1:0] R_PINS_FWD = 2'b01;
  localparam logic [1:0] R_PINS_REV = 2'b10;
  localparam logic [1:0] PINS_COAST = 2'b00;
  localparam logic [1:0] PINS_BRAKE = 2'b11;

  function automatic wheel_e left_cmd(mode_e m);
    case (m)
      M_STRAIGHT, M_LEFT: return W_FWD;
      M_RIGHT:            return W_COAST;
      default:            return W_REV;
    endcase
  endfunction

  function automatic wheel_e right_cmd(mode_e m);
    case (m)
      M_STRAIGHT, M_RIGHT: return W_FWD;
      M_LEFT:              return W_COAST;
      default:             return W_REV;
    endcase
  endfunction

  function automatic logic [1:0] left_pins(wheel_e c);
    case (c)
      W_FWD:   return L_PINS_FWD;
      W_REV:   return L_PINS_REV;
      W_BRAKE: return PINS_BRAKE;
      default: return PINS_COAST;
    endcase
  endfunction

  function automatic logic [1:0] right_pins(wheel_e c);
    case (c)
      W_FWD:   return R_PINS_FWD;
      W_REV:   return R_PINS_REV;
      W_BRAKE: return PINS_BRAKE;
      default: return PINS_COAST;
    endcase
  endfunction

  function automatic logic reversed(wheel_e a, wheel_e b);
    return ((a == W_FWD) && (b == W_REV)) || ((a == W_REV) && (b == W_FWD));
  endfunction

endpackage

// File: rtl/drive_sequencer_if.sv
// Command/response bundle between the tracker/sonic side and the drive sequencer.
interface drive_sequencer_if;
  logic [1:0] mode;
  logic       stop;
  logic [1:0] left;
  logic [1:0] right;
  logic [9:0] left_duty;
  logic [9:0] right_duty;
  logic [2:0] phase;

  modport master (output mode, stop, input left, right, left_duty, right_duty, phase);
  modport slave  (input mode, stop, output left, right, left_duty, right_duty, phase);
endinterface

// File: rtl/drive_sequencer_duty_ramp.sv
// Per-wheel PWM duty register: restart load, immediate drop to a lower target,
// and a saturating step toward the target on each ramp tick.
module duty_ramp #(
  parameter int unsigned RAMP_STEP  = 16,
  parameter int unsigned RAMP_START = 384
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       restart,
  input  logic [9:0] target,
  input  logic       tick,
  output logic [9:0] duty
);
  logic [9:0]  r_duty;
  logic [10:0] w_sum;

  // One extra bit so the step can never wrap past the 10-bit range.
  assign w_sum = {1'b0, r_duty} + 11'(RAMP_STEP);
  assign duty  = r_duty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_duty <= '0;
    end else if (restart) begin
      r_duty <= 10'(RAMP_START);
    end else if (target < r_duty) begin
      r_duty <= target;
    end else if (tick) begin
      r_duty <= (w_sum > {1'b0, target}) ? target : w_sum[9:0];
    end
  end
endmodule

// File: rtl/drive_sequencer.sv
// Two-wheel drive sequencer: maps tracker mode to H-bridge pins and ramped duty,
// with reversal dead-time, obstacle hold-off and a lost-line halt.
module drive_sequencer
  import car_pkg::*;
#(
  parameter int unsigned DEADTIME_CYC = 100_000,
  parameter int unsigned RAMP_DIV     = 1_000,
  parameter int unsigned RAMP_STEP    = 16,
  parameter int unsigned RAMP_START   = 384,
  parameter int unsigned CRUISE_DUTY  = 1023,
  parameter int unsigned LOST_TIMEOUT = 50_000_000,
  parameter int unsigned CLEAR_CYC    = 10_000_000
) (
  input logic              clk,
  input logic              rst,
  drive_sequencer_if.slave bus
);
  localparam int unsigned DT_W = (DEADTIME_CYC > 1) ? $clog2(DEADTIME_CYC) : 1;
  localparam int unsigned TK_W = (RAMP_DIV > 1)     ? $clog2(RAMP_DIV)     : 1;
  localparam int unsigned LS_W = (LOST_TIMEOUT > 1) ? $clog2(LOST_TIMEOUT) : 1;
  localparam int unsigned CL_W = (CLEAR_CYC > 1)    ? $clog2(CLEAR_CYC)    : 1;

  state_e          r_state, w_next;
  mode_e           r_mode, w_mode;
  logic [DT_W-1:0] r_dt;
  logic [TK_W-1:0] r_tick;
  logic [LS_W-1:0] r_lost;
  logic [CL_W-1:0] r_clr;
  logic [1:0]      r_left, r_right;
  wheel_e          w_lcur, w_rcur, w_lnew, w_rnew;
  logic            w_rev, w_lost_done, w_dt_done, w_clr_done, w_tick, w_drive_next;
  logic            w_lrestart, w_rrestart;
  logic [9:0]      w_ltarget, w_rtarget, w_lduty, w_rduty;

  assign w_mode      = mode_e'(bus.mode);
  assign w_lcur      = left_cmd(r_mode);
  assign w_rcur      = right_cmd(r_mode);
  assign w_lnew      = left_cmd(w_mode);
  assign w_rnew      = right_cmd(w_mode);
  assign w_rev       = reversed(w_lcur, w_lnew) || reversed(w_rcur, w_rnew);
  assign w_lost_done = (r_mode == M_BACK) && (r_lost == LS_W'(LOST_TIMEOUT - 1));
  assign w_dt_done   = (r_dt == DT_W'(DEADTIME_CYC - 1));
  assign w_clr_done  = (r_clr == CL_W'(CLEAR_CYC - 1));
  assign w_tick      = (r_state == S_DRIVE) && (r_tick == TK_W'(RAMP_DIV - 1));

  // Branch order encodes the event priority: stop, lost timeout, reversal.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (!bus.stop) w_next = S_DRIVE;
      S_DRIVE: begin
        if (bus.stop)        w_next = S_BLOCKED;
        else if (w_lost_done) w_next = S_LOST_HALT;
        else if (w_rev)       w_next = S_DEADTIME;
      end
      S_DEADTIME: begin
        if (bus.stop)      w_next = S_BLOCKED;
        else if (w_dt_done) w_next = S_DRIVE;
      end
      S_BLOCKED:   if (!bus.stop && w_clr_done) w_next = S_DEADTIME;
      S_LOST_HALT: begin
        if (bus.stop)              w_next = S_BLOCKED;
        else if (w_mode != M_BACK) w_next = S_DEADTIME;
      end
      default:     w_next = S_IDLE;
    endcase
  end

  // Duty targets and restarts follow the state being entered so pins and duty
  // change on the same edge.
  always_comb begin
    w_drive_next = (w_next == S_DRIVE);
    w_ltarget    = (w_drive_next && (w_lnew != W_COAST)) ? 10'(CRUISE_DUTY) : '0;
    w_rtarget    = (w_drive_next && (w_rnew != W_COAST)) ? 10'(CRUISE_DUTY) : '0;
    w_lrestart   = w_drive_next && (w_lnew != W_COAST) &&
                   ((r_state != S_DRIVE) || (w_lcur == W_COAST));
    w_rrestart   = w_drive_next && (w_rnew != W_COAST) &&
                   ((r_state != S_DRIVE) || (w_rcur == W_COAST));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_mode  <= M_STRAIGHT;
      r_dt    <= '0;
      r_tick  <= '0;
      r_lost  <= '0;
      r_clr   <= '0;
      r_left  <= PINS_COAST;
      r_right <= PINS_COAST;
    end else begin
      r_state <= w_next;
      if (w_next == S_DRIVE) r_mode <= w_mode;

      if ((r_state == S_DRIVE) && (w_next == S_DRIVE))
        r_tick <= (r_tick == TK_W'(RAMP_DIV - 1)) ? '0 : r_tick + 1'b1;
      else
        r_tick <= '0;

      if ((r_state == S_DRIVE) && (w_next == S_DRIVE) && (r_mode == M_BACK))
        r_lost <= r_lost + 1'b1;
      else
        r_lost <= '0;

      r_dt  <= ((r_state == S_DEADTIME) && (w_next == S_DEADTIME)) ? r_dt + 1'b1 : '0;
      r_clr <= ((r_state == S_BLOCKED) && (w_next == S_BLOCKED) && !bus.stop) ?
               r_clr + 1'b1 : '0;

      case (w_next)
        S_DRIVE: begin
          r_left  <= left_pins(w_lnew);
          r_right <= right_pins(w_rnew);
        end
        S_BLOCKED, S_LOST_HALT: begin
          r_left  <= PINS_BRAKE;
          r_right <= PINS_BRAKE;
        end
        default: begin
          r_left  <= PINS_COAST;
          r_right <= PINS_COAST;
        end
      endcase
    end
  end

  duty_ramp #(.RAMP_STEP(RAMP_STEP), .RAMP_START(RAMP_START)) u_left_ramp (
    .clk(clk), .rst(rst), .restart(w_lrestart), .target(w_ltarget),
    .tick(w_tick), .duty(w_lduty)
  );

  duty_ramp #(.RAMP_STEP(RAMP_STEP), .RAMP_START(RAMP_START)) u_right_ramp (
    .clk(clk), .rst(rst), .restart(w_rrestart), .target(w_rtarget),
    .tick(w_tick), .duty(w_rduty)
  );

  assign bus.left       = r_left;
  assign bus.right      = r_right;
  assign bus.left_duty  = w_lduty;
  assign bus.right_duty = w_rduty;
  assign bus.phase      = r_state;
endmodule

// File: tb/tb_drive_sequencer.sv
// Bench for drive_sequencer: constant vector table, directed corner sequences
// and random stimulus against a cycle-level behavioural model.
module tb_drive_sequencer;
  localparam int DT    = 8;
  localparam int RDIV  = 4;
  localparam int STEP  = 16;
  localparam int START = 384;
  localparam int CRUISE = 1023;
  localparam int LOST  = 32;
  localparam int CLR   = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  drive_sequencer_if bus();

  drive_sequencer #(
    .DEADTIME_CYC(DT), .RAMP_DIV(RDIV), .RAMP_STEP(STEP), .RAMP_START(START),
    .CRUISE_DUTY(CRUISE), .LOST_TIMEOUT(LOST), .CLEAR_CYC(CLR)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: phase, cycles spent in that phase, stop-low run while blocked,
  // applied mode, and ramp ticks each wheel has seen since its last restart.
  int m_ph = 0, m_age = 0, m_low = 0, m_am = 0, m_lk = 0, m_rk = 0;

  function automatic int lc(int m);
    return (m == 3) ? -1 : (m == 2) ? 0 : 1;
  endfunction
  function automatic int rc(int m);
    return (m == 3) ? -1 : (m == 1) ? 0 : 1;
  endfunction
  function automatic int lpin(int c);
    return (c > 0) ? 2 : (c < 0) ? 1 : 0;
  endfunction
  function automatic int rpin(int c);
    return (c > 0) ? 1 : (c < 0) ? 2 : 0;
  endfunction
  function automatic int ramp(int c, int k);
    int v;
    if (c == 0) return 0;
    v = START + STEP * k;
    return (v > CRUISE) ? CRUISE : v;
  endfunction

  task automatic model_step(input bit r, input int m, input bit s);
    int nx;
    bit tick;
    if (r) begin
      m_ph = 0; m_age = 0; m_low = 0; m_am = 0; m_lk = 0; m_rk = 0;
      return;
    end
    nx = m_ph;
    case (m_ph)
      0: if (!s) nx = 1;
      1: begin
        if (s) nx = 3;
        else if (m_am == 3 && m_age == LOST - 1) nx = 4;
        else if (lc(m_am) * lc(m) < 0 || rc(m_am) * rc(m) < 0) nx = 2;
      end
      2: begin
        if (s) nx = 3;
        else if (m_age == DT - 1) nx = 1;
      end
      3: begin
        m_low = s ? 0 : m_low + 1;
        if (m_low == CLR) nx = 2;
      end
      default: begin
        if (s) nx = 3;
        else if (m != 3) nx = 2;
      end
    endcase
    if (nx == 1) begin
      tick = (m_ph == 1) && ((m_age + 1) % RDIV == 0);
      if (m_ph != 1 || lc(m_am) == 0) m_lk = 0; else if (tick) m_lk++;
      if (m_ph != 1 || rc(m_am) == 0) m_rk = 0; else if (tick) m_rk++;
      m_am = m;
    end
    if (nx == m_ph) m_age++;
    else begin
      m_age = 0;
      m_low = 0;
    end
    m_ph = nx;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s @%0t got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic apply(input bit r, input int m, input bit s);
    rst = r;
    bus.mode = 2'(m);
    bus.stop = s;
    @(posedge clk);
    #1;
    model_step(r, m, s);
  endtask

  task automatic cmp_model(input string tag);
    int el, er;
    el = (m_ph == 1) ? lpin(lc(m_am)) : (m_ph == 3 || m_ph == 4) ? 3 : 0;
    er = (m_ph == 1) ? rpin(rc(m_am)) : (m_ph == 3 || m_ph == 4) ? 3 : 0;
    chk({tag, ".phase"}, int'(bus.phase), m_ph);
    chk({tag, ".left"}, int'(bus.left), el);
    chk({tag, ".right"}, int'(bus.right), er);
    chk({tag, ".left_duty"}, int'(bus.left_duty), (m_ph == 1) ? ramp(lc(m_am), m_lk) : 0);
    chk({tag, ".right_duty"}, int'(bus.right_duty), (m_ph == 1) ? ramp(rc(m_am), m_rk) : 0);
  endtask

  task automatic run(input string tag, input int n, input bit r, input int m, input bit s);
    for (int i = 0; i < n; i++) begin
      apply(r, m, s);
      cmp_model(tag);
    end
  endtask

  typedef struct packed {
    logic       rst;
    logic [1:0] mode;
    logic       stop;
    logic [2:0] ph;
    logic [1:0] l;
    logic [1:0] r;
    logic [9:0] ld;
    logic [9:0] rd;
  } vec_t;

  vec_t tbl[16];
  bit cur_stop;
  int cur_mode;

  initial begin
    tbl[0]  = '{1'b1, 2'd0, 1'b0, 3'd0, 2'b00, 2'b00, 10'd0,   10'd0};
    tbl[1]  = '{1'b1, 2'd0, 1'b0, 3'd0, 2'b00, 2'b00, 10'd0,   10'd0};
    tbl[2]  = '{1'b1, 2'd0, 1'b0, 3'd0, 2'b00, 2'b00, 10'd0,   10'd0};
    tbl[3]  = '{1'b0, 2'd0, 1'b0, 3'd1, 2'b10, 2'b01, 10'd384, 10'd384};
    tbl[4]  = '{1'b0, 2'd0, 1'b0, 3'd1, 2'b10, 2'b01, 10'd384, 10'd384};
    tbl[5]  = '{1'b0, 2'd0, 1'b0, 3'd1, 2'b10, 2'b01, 10'd384, 10'd384};
    tbl[6]  = '{1'b0, 2'd0, 1'b0, 3'd1, 2'b10, 2'b01, 10'd384, 10'd384};
    tbl[7]  = '{1'b0, 2'd0, 1'b0, 3'd1, 2'b10, 2'b01, 10'd400, 10'd400};
    tbl[8]  = '{1'b0, 2'd0, 1'b0, 3'd1, 2'b10, 2'b01, 10'd400, 10'd400};
    tbl[9]  = '{1'b0, 2'd0, 1'b0, 3'd1, 2'b10, 2'b01, 10'd400, 10'd400};
    tbl[10] = '{1'b0, 2'd0, 1'b0, 3'd1, 2'b10, 2'b01, 10'd400, 10'd400};
    tbl[11] = '{1'b0, 2'd0, 1'b0, 3'd1, 2'b10, 2'b01, 10'd416, 10'd416};
    tbl[12] = '{1'b0, 2'd1, 1'b0, 3'd1, 2'b10, 2'b00, 10'd416, 10'd0};
    tbl[13] = '{1'b0, 2'd2, 1'b0, 3'd1, 2'b00, 2'b01, 10'd0,   10'd384};
    tbl[14] = '{1'b0, 2'd2, 1'b1, 3'd3, 2'b11, 2'b11, 10'd0,   10'd0};
    tbl[15] = '{1'b0, 2'd2, 1'b0, 3'd3, 2'b11, 2'b11, 10'd0,   10'd0};

    for (int i = 0; i < 16; i++) begin
      apply(tbl[i].rst, int'(tbl[i].mode), tbl[i].stop);
      chk($sformatf("vec%0d.phase", i), int'(bus.phase), int'(tbl[i].ph));
      chk($sformatf("vec%0d.left", i), int'(bus.left), int'(tbl[i].l));
      chk($sformatf("vec%0d.right", i), int'(bus.right), int'(tbl[i].r));
      chk($sformatf("vec%0d.left_duty", i), int'(bus.left_duty), int'(tbl[i].ld));
      chk($sformatf("vec%0d.right_duty", i), int'(bus.right_duty), int'(tbl[i].rd));
    end

    // Startup, full ramp to saturation, then a left turn at cruise duty.
    run("rst", 3, 1'b1, 0, 1'b0);
    run("ramp", 175, 1'b0, 0, 1'b0);
    chk("ramp_saturated", int'(bus.left_duty), CRUISE);
    run("left_turn", 4, 1'b0, 1, 1'b0);
    chk("left_turn_kept", int'(bus.left_duty), CRUISE);
    run("straight_again", 6, 1'b0, 0, 1'b0);

    // Reversal dead-time, then lost-line halt and recovery to a right turn.
    run("reverse", 45, 1'b0, 3, 1'b0);
    chk("lost_halt_phase", int'(bus.phase), 4);
    run("lost_exit", 12, 1'b0, 2, 1'b0);
    chk("lost_exit_rduty", int'(bus.right_duty), ramp(1, m_rk));

    // Obstacle mid-ramp with a one-cycle glitch in the clear window.
    run("pre_block", 10, 1'b0, 0, 1'b0);
    run("block", 3, 1'b0, 0, 1'b1);
    run("clear_a", 6, 1'b0, 0, 1'b0);
    run("glitch", 1, 1'b0, 0, 1'b1);
    run("clear_b", 22, 1'b0, 0, 1'b0);

    // Reset asserted mid-dead-time together with stop and mode 11.
    run("to_dt", 3, 1'b0, 3, 1'b0);
    chk("in_deadtime", int'(bus.phase), 2);
    run("rst_mid_dt", 1, 1'b1, 3, 1'b1);
    run("idle_hold", 5, 1'b0, 3, 1'b1);
    run("restart", 10, 1'b0, 0, 1'b0);

    cur_stop = 1'b0;
    cur_mode = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0) cur_stop = ~cur_stop;
      if ($urandom_range(0, 24) == 0) cur_mode = int'($urandom_range(0, 3));
      apply($urandom_range(0, 599) == 0, cur_mode, cur_stop);
      cmp_model("rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
